// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - start/operand handshake and result bundle for divider_seq
interface divider_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;

    modport master (
        output start, a, b,
        input  ready, done, q, r, dbz
    );

    modport slave (
        input  start, a, b,
        output ready, done, q, r, dbz
    );
endinterface

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - restoring shift-subtract unsigned divider, W cycles per result
// Define DIVIDER_SEQ_DBZ_EN to short-circuit b=0 straight to DONE with the dbz flag.
module divider_seq #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    divider_seq_if.slave  bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  dq_q, dq_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_sh;
    logic [W-1:0]  rem_sub;
    logic          ge;
`ifdef DIVIDER_SEQ_DBZ_EN
    logic          dbz_q, dbz_d;
`endif

    // dq holds the dividend and fills with quotient bits from the LSB as the dividend shifts out
    always_comb begin
        rem_sh  = {rem_q, dq_q[W-1]};
        rem_sub = rem_sh[W-1:0] - b_q;
        ge      = (rem_sh >= {1'b0, b_q});
        state_d = state_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef DIVIDER_SEQ_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dq_d    = bus.a;
                    b_d     = bus.b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIVIDER_SEQ_DBZ_EN
                    dbz_d   = 1'b0;
                    if (bus.b == '0) begin
                        dq_d    = '1;
                        rem_d   = bus.a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = ge ? rem_sub : rem_sh[W-1:0];
                dq_d  = {dq_q[W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dq_q    <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef DIVIDER_SEQ_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
`ifdef DIVIDER_SEQ_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.q     = dq_q;
    assign bus.r     = rem_q;
`ifdef DIVIDER_SEQ_DBZ_EN
    assign bus.dbz   = dbz_q;
`else
    assign bus.dbz   = 1'b0;
`endif
endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - scoreboard bench for divider_seq (W=8), both DIVIDER_SEQ_DBZ_EN builds
module tb_divider_seq;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    divider_seq_if #(.W(W)) bus ();

    divider_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain / and %, b=0 gives all ones and a; short-circuit latency with the macro.
    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   lat;
        lat = W;
        if (bv == '0) begin
            e.q = '1;
            e.r = av;
`ifdef DIVIDER_SEQ_DBZ_EN
            e.dbz = 1'b1;
            lat   = 0;
`else
            e.dbz = 1'b0;
`endif
        end else begin
            e.q   = av / bv;
            e.r   = av % bv;
            e.dbz = 1'b0;
        end
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        push_exp(av, bv);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) chk("ready_after_done", {31'd0, bus.ready}, 32'd1);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("q", {24'd0, bus.q}, {24'd0, e.q});
                    chk("r", {24'd0, bus.r}, {24'd0, e.r});
                    chk("dbz", {31'd0, bus.dbz}, {31'd0, e.dbz});
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            prev_done <= bus.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    initial begin
        int k;
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dbz", {31'd0, bus.dbz}, 32'd0);
        chk("rst_q", {24'd0, bus.q}, 32'd0);
        chk("rst_r", {24'd0, bus.r}, 32'd0);
        rst = 1'b0;

        run_div(8'd100, 8'd7);
        run_div(8'd255, 8'd1);
        run_div(8'd5, 8'd9);
        run_div(8'd200, 8'd0);
        run_div(8'd0, 8'd3);
        run_div(8'd255, 8'd255);

        // start held high while operands churn; the second accept comes only when ready returns
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd7;
        push_exp(8'd100, 8'd7);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                k = i;
                push_exp(bus.a, bus.b);
                break;
            end
            bus.a = W'($urandom);
            bus.b = W'($urandom_range(1, 255));
        end
        chk("hold_spacing", k, W + 2);
        @(negedge clk);
        bus.start = 1'b0;

        // reset three cycles into a division aborts it
        @(negedge clk);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = 8'd77;
        bus.b     = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_q", {24'd0, bus.q}, 32'd0);
        chk("abort_r", {24'd0, bus.r}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd7;
        push_exp(8'd100, 8'd7);
        @(negedge clk);
        bus.start = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            run_div(W'($urandom), W'($urandom_range(1, 255)));
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
